// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// The slave modport is the arbiter's view; master is the CPU/RAM environment.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 16
);
  localparam int unsigned DATA_W = 16 * MAX_WORDS;

  logic              fetch_start;
  logic              rd_start;
  logic              wr_start;
  logic [ADDR_W-1:0] fetch_address;
  logic [ADDR_W-1:0] rd_address;
  logic [ADDR_W-1:0] wr_address;
  logic [15:0]       fetch_words;
  logic [15:0]       rd_words;
  logic [15:0]       wr_words;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fetch_data;
  logic [DATA_W-1:0] rd_data;
  logic              fetch_done;
  logic              rd_done;
  logic              wr_done;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              busy;

  modport slave (
    input  fetch_start, rd_start, wr_start,
    input  fetch_address, rd_address, wr_address,
    input  fetch_words, rd_words, wr_words,
    input  wr_data, ram_rdata,
    output fetch_data, rd_data, fetch_done, rd_done, wr_done,
    output ram_address, ram_wren, ram_wdata, busy
  );

  modport master (
    output fetch_start, rd_start, wr_start,
    output fetch_address, rd_address, wr_address,
    output fetch_words, rd_words, wr_words,
    output wr_data, ram_rdata,
    input  fetch_data, rd_data, fetch_done, rd_done, wr_done,
    input  ram_address, ram_wren, ram_wdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port 16-bit data RAM between fetch, stack read and stack write.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority wr > rd > fetch.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 16
) (
  input logic              clock,
  input logic              reset_n,
  ram_port_arbiter_if.slave bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DATA_W = WORD_W * MAX_WORDS;
  localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, XFER, DONE, RELEASE} state_t;
  typedef enum logic [1:0] {REQ_FETCH, REQ_RD, REQ_WR} req_t;

  state_t            state;
  req_t              grant;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] fetch_q;
  logic [DATA_W-1:0] rd_q;
  logic              fetch_done_q;
  logic              rd_done_q;
  logic              wr_done_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_wren_q;
  logic [WORD_W-1:0] ram_wdata_q;
  logic              busy_q;
`ifdef ARB_ROUND_ROBIN_EN
  req_t              rr_ptr;
`endif

  logic              gnt_valid_c;
  req_t              gnt_sel_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic [15:0]       gnt_words_c;
  logic [CNT_W-1:0]  gnt_len_c;
  logic              gnt_start_c;
  logic [IDX_W-1:0]  cap_hi_c;

  // Arbitration, effective length and read-capture position.
  always_comb begin
    gnt_valid_c = bus.fetch_start | bus.rd_start | bus.wr_start;
    gnt_sel_c   = REQ_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
    // Search starts after the last served requester, order wr -> rd -> fetch -> wr.
    case (rr_ptr)
      REQ_WR: begin
        if      (bus.rd_start)    gnt_sel_c = REQ_RD;
        else if (bus.fetch_start) gnt_sel_c = REQ_FETCH;
        else if (bus.wr_start)    gnt_sel_c = REQ_WR;
      end
      REQ_RD: begin
        if      (bus.fetch_start) gnt_sel_c = REQ_FETCH;
        else if (bus.wr_start)    gnt_sel_c = REQ_WR;
        else if (bus.rd_start)    gnt_sel_c = REQ_RD;
      end
      default: begin
        if      (bus.wr_start)    gnt_sel_c = REQ_WR;
        else if (bus.rd_start)    gnt_sel_c = REQ_RD;
        else if (bus.fetch_start) gnt_sel_c = REQ_FETCH;
      end
    endcase
`else
    if      (bus.wr_start) gnt_sel_c = REQ_WR;
    else if (bus.rd_start) gnt_sel_c = REQ_RD;
`endif
    if (gnt_sel_c == REQ_WR) begin
      gnt_addr_c  = bus.wr_address;
      gnt_words_c = bus.wr_words;
    end else if (gnt_sel_c == REQ_RD) begin
      gnt_addr_c  = bus.rd_address;
      gnt_words_c = bus.rd_words;
    end else begin
      gnt_addr_c  = bus.fetch_address;
      gnt_words_c = bus.fetch_words;
    end
    gnt_len_c = (gnt_words_c > 16'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : CNT_W'(gnt_words_c);
    gnt_start_c = (grant == REQ_WR) ? bus.wr_start :
                  (grant == REQ_RD) ? bus.rd_start : bus.fetch_start;
    // Word cnt-1 lands at bits [DATA_W-1-16*(cnt-1) -: 16]; only used when cnt >= 1.
    cap_hi_c = IDX_W'(DATA_W + WORD_W - 1 - WORD_W * int'(cnt));
  end

  // Control FSM with registered RAM and requester outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant         <= REQ_FETCH;
      len           <= '0;
      cnt           <= '0;
      wbuf          <= '0;
      fetch_q       <= '0;
      rd_q          <= '0;
      fetch_done_q  <= 1'b0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_wdata_q   <= '0;
      busy_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr        <= REQ_FETCH;
`endif
    end else begin
      fetch_done_q <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid_c) begin
            grant  <= gnt_sel_c;
            len    <= gnt_len_c;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr <= gnt_sel_c;
`endif
            if (gnt_sel_c == REQ_FETCH) fetch_q <= '0;
            if (gnt_sel_c == REQ_RD)    rd_q    <= '0;
            if (gnt_len_c == '0) begin
              state        <= DONE;
              fetch_done_q <= (gnt_sel_c == REQ_FETCH);
              rd_done_q    <= (gnt_sel_c == REQ_RD);
              wr_done_q    <= (gnt_sel_c == REQ_WR);
            end else begin
              state         <= XFER;
              ram_address_q <= gnt_addr_c;
              if (gnt_sel_c == REQ_WR) begin
                ram_wren_q  <= 1'b1;
                ram_wdata_q <= bus.wr_data[DATA_W-1 -: WORD_W];
                wbuf        <= bus.wr_data << WORD_W;
              end
            end
          end
        end
        XFER: begin
          if (grant == REQ_WR) begin
            if (cnt == len - CNT_W'(1)) begin
              ram_wren_q <= 1'b0;
              wr_done_q  <= 1'b1;
              state      <= DONE;
            end else begin
              cnt           <= cnt + CNT_W'(1);
              ram_address_q <= ram_address_q + ADDR_W'(1);
              ram_wdata_q   <= wbuf[DATA_W-1 -: WORD_W];
              wbuf          <= wbuf << WORD_W;
            end
          end else begin
            // Read data trails the address by one cycle, hence n+1 cycles here.
            if (cnt != '0) begin
              if (grant == REQ_RD) rd_q[cap_hi_c -: WORD_W]    <= bus.ram_rdata;
              else                 fetch_q[cap_hi_c -: WORD_W] <= bus.ram_rdata;
            end
            if (cnt == len) begin
              fetch_done_q <= (grant == REQ_FETCH);
              rd_done_q    <= (grant == REQ_RD);
              state        <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (cnt + CNT_W'(1) != len) ram_address_q <= ram_address_q + ADDR_W'(1);
            end
          end
        end
        DONE: state <= RELEASE;
        RELEASE: begin
          if (!gnt_start_c) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fetch_data  = fetch_q;
  assign bus.rd_data     = rd_q;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.busy        = busy_q;

endmodule
